// File: rtl/ecc_156_pkg.sv
// ecc_156_pkg: shared constants, position map and parity coverage masks for the 156-bit SECDED code
package ecc_156_pkg;
  localparam int DATA_WIDTH   = 156;
  localparam int PARITY_WIDTH = 9;
  localparam int CNT_WIDTH    = 8;
  localparam int CW_TOP       = DATA_WIDTH + PARITY_WIDTH - 1;

  typedef enum logic [1:0] {
    INJ_NONE   = 2'b00,
    INJ_SINGLE = 2'b01,
    INJ_DOUBLE = 2'b10,
    INJ_NONE3  = 2'b11
  } inj_mode_e;

  function automatic int data_pos(input int j);
    int n;
    n = 0;
    data_pos = 0;
    for (int p = 1; p <= CW_TOP; p++)
      if ((p & (p - 1)) != 0) begin
        if (n == j) data_pos = p;
        n++;
      end
  endfunction

  function automatic logic [DATA_WIDTH-1:0] cov_mask(input int i);
    cov_mask = '0;
    for (int j = 0; j < DATA_WIDTH; j++) cov_mask[j] = ((data_pos(j) >> i) & 1) != 0;
  endfunction

  localparam logic [7:0][DATA_WIDTH-1:0] COV_MASK = {
    cov_mask(7), cov_mask(6), cov_mask(5), cov_mask(4),
    cov_mask(3), cov_mask(2), cov_mask(1), cov_mask(0)
  };
endpackage

// File: rtl/ecc_156_enc.sv
// ecc_156_enc: combinational data -> 9-bit SECDED parity
module ecc_156_enc
  import ecc_156_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]   data,
  output logic [PARITY_WIDTH-1:0] parity
);
  logic [7:0] h;
  // Hamming bits: XOR of data bits whose codeword position has bit i set
  always_comb begin
    h = '0;
    for (int i = 0; i < 8; i++) h[i] = ^(data & COV_MASK[i]);
  end
  assign parity = {^{data, h}, h};
endmodule

// File: rtl/ecc_156_enc_fault_detc.sv
// ecc_156_enc_fault_detc: redundant SECDED encoder with fault compare, output register stage and error injection
module ecc_156_enc_fault_detc
  import ecc_156_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    bypass,
  input  logic                    ecc_fault_detc_en,
  input  logic                    force_mismatch,
  input  logic                    inj_arm,
  input  logic [1:0]              inj_mode,
  input  logic                    fault_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [PARITY_WIDTH-1:0] parity_out,
  output logic                    ecc_fault,
  output logic                    fault_sticky,
  output logic [CNT_WIDTH-1:0]    fault_cnt,
  output logic                    inj_pending
);
  logic [PARITY_WIDTH-1:0] enc0, enc1_raw, enc1;
  logic accept, mismatch, inj_apply;
  logic [1:0] flip2;
  logic [DATA_WIDTH-1:0] inj_flip;
  logic out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [PARITY_WIDTH-1:0] parity_q, parity_d;
  logic ecc_fault_q, ecc_fault_d;
  logic fault_sticky_q, fault_sticky_d;
  logic [CNT_WIDTH-1:0] fault_cnt_q, fault_cnt_d;
  logic inj_pending_q, inj_pending_d;
  inj_mode_e inj_mode_q, inj_mode_d;

  ecc_156_enc u0 (.data(data_in), .parity(enc0));
  ecc_156_enc u1 (.data(data_in), .parity(enc1_raw));

  assign enc1      = enc1_raw ^ {{(PARITY_WIDTH-1){1'b0}}, force_mismatch};
  assign in_ready  = ~out_valid_q | out_ready;
  assign accept    = in_valid & in_ready;
  assign mismatch  = (enc0 != enc1) & ecc_fault_detc_en & ~bypass;
  // an arm in the same cycle as an accept targets the following beat
  assign inj_apply = inj_pending_q & ~inj_arm & ~bypass;
  assign flip2     = inj_mode_q == INJ_SINGLE ? 2'b01 : inj_mode_q == INJ_DOUBLE ? 2'b11 : 2'b00;
  assign inj_flip  = DATA_WIDTH'(inj_apply ? flip2 : 2'b00);

  // next state of the output stage, fault bookkeeping and injection arm
  always_comb begin
    out_valid_d    = accept | (out_valid_q & ~out_ready);
    data_d         = accept ? data_in ^ inj_flip : data_q;
    parity_d       = accept ? (bypass ? '0 : enc0) : parity_q;
    ecc_fault_d    = accept ? mismatch : ecc_fault_q;
    fault_sticky_d = fault_clr ? 1'b0 : fault_sticky_q | (accept & mismatch);
    fault_cnt_d    = fault_clr ? '0 : (accept & mismatch & ~&fault_cnt_q) ? fault_cnt_q + 1'b1 : fault_cnt_q;
    inj_pending_d  = inj_arm | (inj_pending_q & ~accept);
    inj_mode_d     = inj_arm ? inj_mode_e'(inj_mode) : inj_mode_q;
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      data_q         <= '0;
      parity_q       <= '0;
      ecc_fault_q    <= 1'b0;
      fault_sticky_q <= 1'b0;
      fault_cnt_q    <= '0;
      inj_pending_q  <= 1'b0;
      inj_mode_q     <= INJ_NONE;
    end else begin
      out_valid_q    <= out_valid_d;
      data_q         <= data_d;
      parity_q       <= parity_d;
      ecc_fault_q    <= ecc_fault_d;
      fault_sticky_q <= fault_sticky_d;
      fault_cnt_q    <= fault_cnt_d;
      inj_pending_q  <= inj_pending_d;
      inj_mode_q     <= inj_mode_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign data_out     = data_q;
  assign parity_out   = parity_q;
  assign ecc_fault    = ecc_fault_q;
  assign fault_sticky = fault_sticky_q;
  assign fault_cnt    = fault_cnt_q;
  assign inj_pending  = inj_pending_q;
endmodule
